// File: rtl/wb2reg_pkg.sv
// Shared types and constants for the Wishbone-to-register-bus bridge.
package wb2reg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } wb2reg_st_e;

  localparam logic [31:0] WB2REG_ERR_DATA = 32'h0BAD_0BAD;

endpackage

// File: rtl/wb2reg_if.sv
// Classic single-cycle Wishbone slave-port signal bundle.
interface wb2reg_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();

  logic            wbs_cyc_i;
  logic            wbs_stb_i;
  logic [AW-1:0]   wbs_adr_i;
  logic            wbs_we_i;
  logic [DW-1:0]   wbs_dat_i;
  logic [DW/8-1:0] wbs_sel_i;
  logic [DW-1:0]   wbs_dat_o;
  logic            wbs_ack_o;
  logic            wbs_err_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_adr_i, wbs_we_i, wbs_dat_i, wbs_sel_i,
    input  wbs_dat_o, wbs_ack_o, wbs_err_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_adr_i, wbs_we_i, wbs_dat_i, wbs_sel_i,
    output wbs_dat_o, wbs_ack_o, wbs_err_o
  );

endinterface

// File: rtl/wb2reg.sv
// Wishbone slave to register-bus bridge: one registered register request per
// Wishbone cycle, completed by reg_ack or by a bounded timeout.
module wb2reg
  import wb2reg_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TMO_W   = 8,
  parameter int TMO_CYC = 255
) (
  input  logic            mclk,
  input  logic            reset_n,
  wb2reg_if.slave         wbs,
  output logic            reg_cs,
  output logic            reg_wr,
  output logic [AW-1:0]   reg_addr,
  output logic [DW/8-1:0] reg_be,
  output logic [DW-1:0]   reg_wdata,
  input  logic [DW-1:0]   reg_rdata,
  input  logic            reg_ack
);

  localparam logic [DW-1:0]    ERR_DATA = DW'(WB2REG_ERR_DATA);
  localparam bit               TMO_EN   = (TMO_CYC != 0);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  wb2reg_st_e        r_state;
  logic [TMO_W-1:0]  r_cnt;
  logic              r_abort;
  logic              r_cs;
  logic              r_wr;
  logic [AW-1:0]     r_addr;
  logic [DW/8-1:0]   r_be;
  logic [DW-1:0]     r_wdata;
  logic [DW-1:0]     r_dat_o;
  logic              r_ack;
  logic              r_err;

  logic              w_tmo;
  logic              w_deliver;

  assign w_tmo     = TMO_EN && (r_cnt == TMO_LAST);
  // The completion pulse is decided on the REQ->RESP edge so it can be
  // registered; a cyc drop seen on that same edge counts as an abort.
  assign w_deliver = !r_abort && wbs.wbs_cyc_i;

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_abort <= 1'b0;
      r_cs    <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
      r_dat_o <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (wbs.wbs_cyc_i && wbs.wbs_stb_i) begin
            r_addr  <= wbs.wbs_adr_i;
            r_wr    <= wbs.wbs_we_i;
            r_wdata <= wbs.wbs_dat_i;
            r_be    <= wbs.wbs_sel_i;
            r_cs    <= 1'b1;
            r_cnt   <= '0;
            r_abort <= 1'b0;
            r_state <= REQ;
          end
        end
        REQ: begin
          r_cnt <= r_cnt + 1'b1;
          if (!wbs.wbs_cyc_i) begin
            r_abort <= 1'b1;
          end
          if (reg_ack) begin
            r_cs <= 1'b0;
            if (!r_wr) begin
              r_dat_o <= reg_rdata;
            end
            r_ack   <= w_deliver;
            r_state <= RESP;
          end else if (w_tmo) begin
            r_cs    <= 1'b0;
            r_dat_o <= ERR_DATA;
            r_err   <= w_deliver;
            r_state <= RESP;
          end
        end
        RESP: begin
          r_abort <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign reg_cs        = r_cs;
  assign reg_wr        = r_wr;
  assign reg_addr      = r_addr;
  assign reg_be        = r_be;
  assign reg_wdata     = r_wdata;
  assign wbs.wbs_dat_o = r_dat_o;
  assign wbs.wbs_ack_o = r_ack;
  assign wbs.wbs_err_o = r_err;

endmodule

// File: tb/tb_wb2reg.sv
// Bench for wb2reg: two instances (timeout 4 and timeout disabled) share stimulus
// and are checked cycle by cycle against a transaction-level outcome model.
module tb_wb2reg;

  localparam int TMO_A = 4;
  localparam int TMO_B = 0;

  logic        mclk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  cyc = '0;
  logic [1:0]  stb = '0;
  logic        we = 1'b0;
  logic [31:0] adr = '0;
  logic [31:0] wdat = '0;
  logic [3:0]  sel = '0;
  logic [31:0] rdata = '0;
  logic        reg_ack = 1'b0;

  logic [1:0]  cs, wr, ack_o, err_o;
  logic [31:0] raddr [2];
  logic [31:0] rwd [2];
  logic [3:0]  rbe [2];
  logic [31:0] dat_o [2];

  logic [31:0] exp_dat [2];
  int          n_total = 0;
  int          n_pass = 0;

  always #5 mclk = ~mclk;

  wb2reg_if #(.AW(32), .DW(32)) ifa ();
  wb2reg_if #(.AW(32), .DW(32)) ifb ();

  assign ifa.wbs_cyc_i = cyc[0];
  assign ifa.wbs_stb_i = stb[0];
  assign ifa.wbs_adr_i = adr;
  assign ifa.wbs_we_i  = we;
  assign ifa.wbs_dat_i = wdat;
  assign ifa.wbs_sel_i = sel;
  assign ifb.wbs_cyc_i = cyc[1];
  assign ifb.wbs_stb_i = stb[1];
  assign ifb.wbs_adr_i = adr;
  assign ifb.wbs_we_i  = we;
  assign ifb.wbs_dat_i = wdat;
  assign ifb.wbs_sel_i = sel;

  assign ack_o[0] = ifa.wbs_ack_o;
  assign err_o[0] = ifa.wbs_err_o;
  assign dat_o[0] = ifa.wbs_dat_o;
  assign ack_o[1] = ifb.wbs_ack_o;
  assign err_o[1] = ifb.wbs_err_o;
  assign dat_o[1] = ifb.wbs_dat_o;

  wb2reg #(.AW(32), .DW(32), .TMO_W(8), .TMO_CYC(TMO_A)) dut_a (
    .mclk(mclk), .reset_n(reset_n), .wbs(ifa),
    .reg_cs(cs[0]), .reg_wr(wr[0]), .reg_addr(raddr[0]), .reg_be(rbe[0]),
    .reg_wdata(rwd[0]), .reg_rdata(rdata), .reg_ack(reg_ack)
  );

  wb2reg #(.AW(32), .DW(32), .TMO_W(8), .TMO_CYC(TMO_B)) dut_b (
    .mclk(mclk), .reset_n(reset_n), .wbs(ifb),
    .reg_cs(cs[1]), .reg_wr(wr[1]), .reg_addr(raddr[1]), .reg_be(rbe[1]),
    .reg_wdata(rwd[1]), .reg_rdata(rdata), .reg_ack(reg_ack)
  );

  function automatic int tmo_of(input int i);
    return (i == 0) ? TMO_A : TMO_B;
  endfunction

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    cyc = '0; stb = '0; reg_ack = 1'b0;
    we = 1'b0; adr = '0; wdat = '0; sel = '0; rdata = '0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    exp_dat[0] = '0;
    exp_dat[1] = '0;
  endtask

  // One Wishbone transaction. ack_dly: REQ cycle index in which reg_ack is
  // driven (-1 = never); drop_at: cycle index at which the master drops cyc.
  task automatic run_txn(input string tag, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] rd,
                         input logic [3:0] s, input int ack_dly, input int drop_at);
    int          n [2];
    bit          to [2];
    bit          ab [2];
    logic [31:0] nd [2];
    int          last;
    last = 0;
    for (int i = 0; i < 2; i++) begin
      int t;
      t     = tmo_of(i);
      to[i] = !(ack_dly >= 0 && (t == 0 || ack_dly < t));
      n[i]  = to[i] ? t - 1 : ack_dly;
      ab[i] = (drop_at >= 0) && (drop_at <= n[i]);
      nd[i] = to[i] ? 32'h0BAD_0BAD : (w ? exp_dat[i] : rd);
      if (n[i] + 2 > last) last = n[i] + 2;
    end
    we = w; adr = a; wdat = d; sel = s; rdata = rd; reg_ack = 1'b0;
    cyc = 2'b11; stb = 2'b11;
    tick();
    for (int k = 0; k <= last; k++) begin
      for (int i = 0; i < 2; i++) begin
        logic        e_cs, e_pl;
        logic [31:0] e_d;
        e_cs = (k <= n[i]);
        e_pl = (k == n[i] + 1) && !ab[i];
        e_d  = (k > n[i]) ? nd[i] : exp_dat[i];
        n_total++;
        if (cs[i] !== e_cs)
          $display("FAIL %s dut%0d k=%0d reg_cs got %b exp %b", tag, i, k, cs[i], e_cs);
        else n_pass++;
        n_total++;
        if (ack_o[i] !== (e_pl && !to[i]))
          $display("FAIL %s dut%0d k=%0d wbs_ack_o got %b exp %b", tag, i, k, ack_o[i], e_pl && !to[i]);
        else n_pass++;
        n_total++;
        if (err_o[i] !== (e_pl && to[i]))
          $display("FAIL %s dut%0d k=%0d wbs_err_o got %b exp %b", tag, i, k, err_o[i], e_pl && to[i]);
        else n_pass++;
        n_total++;
        if (dat_o[i] !== e_d)
          $display("FAIL %s dut%0d k=%0d wbs_dat_o got %h exp %h", tag, i, k, dat_o[i], e_d);
        else n_pass++;
        if (e_cs) begin
          n_total++;
          if ({wr[i], raddr[i], rwd[i], rbe[i]} !== {w, a, d, s})
            $display("FAIL %s dut%0d k=%0d reg_fields got %b/%h/%h/%h exp %b/%h/%h/%h",
                     tag, i, k, wr[i], raddr[i], rwd[i], rbe[i], w, a, d, s);
          else n_pass++;
        end
        if (k == n[i] + 1) begin
          cyc[i] = 1'b0;
          stb[i] = 1'b0;
        end
      end
      if (k == drop_at) begin
        cyc = '0;
        stb = '0;
      end
      reg_ack = (k == ack_dly);
      tick();
    end
    reg_ack = 1'b0; cyc = '0; stb = '0;
    exp_dat[0] = nd[0];
    exp_dat[1] = nd[1];
  endtask

  task automatic test_reset();
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      n_total++;
      if ({cs[i], wr[i], ack_o[i], err_o[i], raddr[i], rwd[i], rbe[i], dat_o[i]} !== '0)
        $display("FAIL reset dut%0d outputs got %b%b%b%b/%h/%h/%h/%h exp all zero",
                 i, cs[i], wr[i], ack_o[i], err_o[i], raddr[i], rwd[i], rbe[i], dat_o[i]);
      else n_pass++;
    end
  endtask

  task automatic test_write();
    run_txn("write", 1'b1, 32'h0000_0010, 32'hA5A5_1234, $urandom, 4'hF, 3, -1);
  endtask

  task automatic test_read();
    run_txn("read", 1'b0, $urandom, $urandom, 32'hDEAD_BEEF, 4'hF, 0, -1);
  endtask

  task automatic test_random();
    for (int j = 0; j < 10; j++)
      run_txn("random", 1'($urandom), $urandom, $urandom, $urandom, 4'($urandom),
              int'($urandom_range(0, 6)), -1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, r, last_r;
    a = $urandom; r = $urandom; last_r = r;
    we = 1'b0; adr = a; rdata = r; sel = 4'hF; reg_ack = 1'b1;
    cyc = 2'b11; stb = 2'b11;
    tick();
    for (int k = 0; k < 18; k++) begin
      for (int i = 0; i < 2; i++) begin
        logic [2:0] e;
        e = (k % 3 == 0) ? 3'b100 : (k % 3 == 1) ? 3'b010 : 3'b000;
        n_total++;
        if ({cs[i], ack_o[i], err_o[i]} !== e)
          $display("FAIL b2b dut%0d k=%0d cs/ack/err got %b exp %b", i, k, {cs[i], ack_o[i], err_o[i]}, e);
        else n_pass++;
        if (k % 3 == 0) begin
          n_total++;
          if (raddr[i] !== a)
            $display("FAIL b2b dut%0d k=%0d reg_addr got %h exp %h", i, k, raddr[i], a);
          else n_pass++;
        end
        if (k % 3 == 1) begin
          n_total++;
          if (dat_o[i] !== r)
            $display("FAIL b2b dut%0d k=%0d wbs_dat_o got %h exp %h", i, k, dat_o[i], r);
          else n_pass++;
        end
      end
      if (k % 3 == 1) begin
        last_r = r;
        a = $urandom; r = $urandom; adr = a; rdata = r;
      end
      if (k == 16) begin
        cyc = '0;
        stb = '0;
      end
      tick();
    end
    reg_ack = 1'b0;
    exp_dat[0] = last_r;
    exp_dat[1] = last_r;
  endtask

  task automatic test_timeout();
    run_txn("timeout", 1'b0, $urandom, $urandom, $urandom, 4'hF, 6, -1);
    run_txn("ack_at_timeout", 1'b0, $urandom, $urandom, $urandom, 4'h3, 3, -1);
  endtask

  task automatic test_no_timeout();
    run_txn("long_wait", 1'b0, $urandom, $urandom, $urandom, 4'hF, 1000, -1);
  endtask

  task automatic test_abort();
    run_txn("abort", 1'b0, $urandom, $urandom, $urandom, 4'hF, 4, 2);
    run_txn("after_abort", 1'b1, $urandom, $urandom, $urandom, 4'hC, 1, -1);
  endtask

  task automatic test_reset_mid();
    run_txn("pre_reset", 1'b0, $urandom, $urandom, $urandom | 32'h1, 4'hF, 0, -1);
    we = 1'b1; adr = $urandom | 32'h1; wdat = $urandom | 32'h1; sel = 4'hF;
    cyc = 2'b11; stb = 2'b11; reg_ack = 1'b0;
    tick();
    tick();
    tick();
    #2 reset_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_total++;
      if ({cs[i], wr[i], ack_o[i], err_o[i], raddr[i], rwd[i], rbe[i], dat_o[i]} !== '0)
        $display("FAIL async_reset dut%0d outputs got %b%b%b%b/%h/%h/%h/%h exp all zero",
                 i, cs[i], wr[i], ack_o[i], err_o[i], raddr[i], rwd[i], rbe[i], dat_o[i]);
      else n_pass++;
    end
    cyc = '0; stb = '0;
    tick();
    reset_n = 1'b1;
    reg_ack = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        n_total++;
        if ({cs[i], ack_o[i], err_o[i]} !== 3'b000)
          $display("FAIL post_reset dut%0d k=%0d cs/ack/err got %b exp 000", i, k, {cs[i], ack_o[i], err_o[i]});
        else n_pass++;
      end
    end
    reg_ack = 1'b0;
    exp_dat[0] = '0;
    exp_dat[1] = '0;
    run_txn("after_reset", 1'b0, $urandom, $urandom, $urandom, 4'hF, 2, -1);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_random();
    test_timeout();
    test_no_timeout();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
